// File: rtl/ssd1306_spi_tx.sv
// Streams a 128x64 mono frame buffer to an SSD1306 over 4-wire SPI (mode 0, MSB first).
// Define SSD1306_TX_CMD_PREAMBLE_EN to prepend the column/page address window commands (dc=0).
module ssd1306_spi_tx #(
  parameter int CLK_DIV  = 4,
  parameter int FB_BYTES = 1024
) (
  input  logic       clk,
  input  logic       greset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [9:0] fb_raddr,
  input  logic [7:0] fb_rdata,
  output logic       wclk,
  output logic       din,
  output logic       cs,
  output logic       dc
);

`ifdef SSD1306_TX_CMD_PREAMBLE_EN
  localparam int PRE_BYTES = 6;
`else
  localparam int PRE_BYTES = 0;
`endif
  localparam int N_BYTES = FB_BYTES + PRE_BYTES;

  typedef enum logic [1:0] {IDLE, PRE, SHIFT, FINISH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  nxt_q, nxt_d;
  logic [1:0]  fetch_q, fetch_d;
  logic        cs_q, cs_d, wclk_q, wclk_d, din_q, din_d;
  logic        dc_q, dc_d, busy_q, busy_d, done_q, done_d;

  logic        accept, div_end, last_byte, byte_end;
  logic [15:0] idx_inc, addr_inc;
  logic [7:0]  next_byte;
  logic        next_is_cmd;

`ifdef SSD1306_TX_CMD_PREAMBLE_EN
  function automatic logic [7:0] pre_rom(input logic [15:0] i);
    case (i)
      16'd0:   pre_rom = 8'h21;
      16'd1:   pre_rom = 8'h00;
      16'd2:   pre_rom = 8'h7F;
      16'd3:   pre_rom = 8'h22;
      16'd4:   pre_rom = 8'h00;
      default: pre_rom = 8'h07;
    endcase
  endfunction
`endif

  // A start landing in the done cycle is dropped even though busy is already low.
  assign accept    = (state_q == IDLE) && start && !busy_q && !done_q;
  assign div_end   = (div_q == 8'(CLK_DIV - 1));
  assign last_byte = (idx_q == 16'(N_BYTES - 1));
  assign byte_end  = div_end && wclk_q && (bit_q == 3'd7);
  assign idx_inc   = idx_q + 16'd1;
  assign addr_inc  = (addr_q == 16'(FB_BYTES - 1)) ? 16'd0 : addr_q + 16'd1;

  always_comb begin
    next_byte   = nxt_q;
    next_is_cmd = 1'b0;
`ifdef SSD1306_TX_CMD_PREAMBLE_EN
    if (idx_inc < 16'(PRE_BYTES)) begin
      next_byte   = pre_rom(idx_inc);
      next_is_cmd = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (greset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SSD1306_TX_CMD_PREAMBLE_EN
          state_d = PRE;
`else
          state_d = SHIFT;
`endif
        end
      end
      PRE, SHIFT: begin
        if (byte_end) begin
          if (last_byte)         state_d = FINISH;
          else if (!next_is_cmd) state_d = SHIFT;
        end
      end
      FINISH:  if (div_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    nxt_d   = nxt_q;
    fetch_d = {fetch_q[0], 1'b0};
    cs_d    = cs_q;
    wclk_d  = wclk_q;
    din_d   = din_q;
    dc_d    = dc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // fb_rdata answers the address presented one cycle earlier
    if (fetch_q[1]) nxt_d = fb_rdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          div_d      = 8'd0;
          bit_d      = 3'd0;
          idx_d      = 16'd0;
          wclk_d     = 1'b0;
          fetch_d[0] = 1'b1;
`ifdef SSD1306_TX_CMD_PREAMBLE_EN
          shreg_d    = pre_rom(16'd0);
          din_d      = shreg_d[7];
          dc_d       = 1'b0;
`else
          shreg_d    = fb_rdata;
          din_d      = fb_rdata[7];
          dc_d       = 1'b1;
          addr_d     = addr_inc;
`endif
        end
      end
      PRE, SHIFT: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) begin
          wclk_d = ~wclk_q;
          if (wclk_q && bit_q != 3'd7) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            din_d   = shreg_q[6];
            bit_d   = bit_q + 3'd1;
          end else if (byte_end && !last_byte) begin
            shreg_d = next_byte;
            din_d   = next_byte[7];
            bit_d   = 3'd0;
            idx_d   = idx_inc;
            dc_d    = ~next_is_cmd;
            if (!next_is_cmd) begin
              addr_d     = addr_inc;
              fetch_d[0] = 1'b1;
            end
          end
        end
      end
      FINISH: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) begin
          cs_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          din_d  = 1'b0;
          addr_d = 16'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (greset) begin
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      idx_q   <= 16'd0;
      addr_q  <= 16'd0;
      shreg_q <= 8'd0;
      nxt_q   <= 8'd0;
      fetch_q <= 2'd0;
      cs_q    <= 1'b1;
      wclk_q  <= 1'b0;
      din_q   <= 1'b0;
      dc_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      nxt_q   <= nxt_d;
      fetch_q <= fetch_d;
      cs_q    <= cs_d;
      wclk_q  <= wclk_d;
      din_q   <= din_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fb_raddr = addr_q[9:0];
  assign wclk     = wclk_q;
  assign din      = din_q;
  assign cs       = cs_q;
  assign dc       = dc_q;

endmodule

// File: doc/ssd1306_spi_tx.md
SSD1306_SPI_TX -- requirements
Module: ssd1306_spi_tx

Interface
REQ-001 Parameters SHALL be:
- CLK_DIV, 4, clk cycles per SCLK half-period (legal range 1..255)
- FB_BYTES, 1024, bytes per frame (128x64 mono, page-major)

REQ-002 Ports SHALL be:
- clk  in  1  single system clock; all logic on posedge clk
- greset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse requesting one frame transfer
- busy  out  1  high from start acceptance until the done cycle inclusive
- done  out  1  one-cycle pulse at end of frame
- fb_raddr  out  10  frame-buffer byte address
- fb_rdata  in  8  frame-buffer byte; valid exactly one clk after fb_raddr
- wclk  out  1  SPI clock; idles low
- din  out  1  SPI data, MSB first
- cs  out  1  chip select, active low; idles high
- dc  out  1  low = command byte, high = data byte

Function
REQ-003 The block SHALL implement SPI mode 0: din changes only while wclk is low; the receiver samples on wclk rising.
REQ-004 States SHALL be IDLE, PRE, SHIFT, FINISH.
REQ-005 In IDLE, start=1 with busy=0 SHALL be accepted; busy rises the next cycle; start while busy=1 SHALL be ignored.
REQ-006 cs SHALL fall the cycle after acceptance (T0); the first wclk rising edge SHALL occur at T0+CLK_DIV.
REQ-007 Each bit SHALL be wclk low for CLK_DIV cycles, then high for CLK_DIV cycles; no extra cycles between bits or bytes.
REQ-008 din for bit 7 of the first byte SHALL be valid at T0; each following bit SHALL update on the cycle wclk falls.
REQ-009 Data bytes SHALL be sent in address order 0..FB_BYTES-1 with dc=1; byte n+1 SHALL be prefetched during byte n so fetch never stalls wclk.
REQ-010 fb_raddr SHALL be 16-bit-safe and wrap only at FB_BYTES; it SHALL be 0 in IDLE.
REQ-011 cs SHALL stay low for the whole frame and rise CLK_DIV cycles after the last wclk falling edge (FINISH).
REQ-012 done SHALL pulse, and busy SHALL fall, in the cycle cs rises; start in that same cycle SHALL be ignored.
REQ-013 Frame duration from T0 to cs rise SHALL be (2*8*N + 1)*CLK_DIV cycles, N = total bytes sent.
REQ-014 A frame SHALL never be truncated except by greset.

Reset
REQ-015 greset SHALL force, on the next clk edge: state IDLE, cs=1, wclk=0, din=0, dc=1, busy=0, done=0, fb_raddr=0.
REQ-016 greset mid-frame SHALL abort with no done pulse; the next start SHALL begin a complete frame from byte 0.
REQ-017 greset SHALL take priority over start in the same cycle.

Configuration
REQ-018 Macro SSD1306_TX_CMD_PREAMBLE_EN SHALL control the address preamble.
REQ-019 With SSD1306_TX_CMD_PREAMBLE_EN defined: state PRE SHALL send 6 command bytes 0x21,0x00,0x7F,0x22,0x00,0x07 with dc=0 before data, in the same cs window and bit timing; dc SHALL switch to 1 in the cycle bit 7 of data byte 0 is driven; N = FB_BYTES+6.
REQ-020 Without it: PRE SHALL be absent, dc SHALL be constantly 1, N = FB_BYTES.

Verification
REQ-021 CLK_DIV=1, FB_BYTES=4, fb bytes A5,3C,FF,00, no macro, start pulse -> cs low 65 cycles, 32 wclk rises, sampled din stream = A53CFF00 MSB first, one done pulse.
REQ-022 CLK_DIV=4, FB_BYTES=1024, no macro -> first wclk rise at T0+4, cs rises at T0+65540, no gap between bytes, 8192 wclk rises.
REQ-023 Macro defined, CLK_DIV=2, FB_BYTES=2, data 81,7E -> stream 21,00,7F,22,00,07,81,7E; dc=0 for first 48 rising-edge samples, 1 for last 16.
REQ-024 greset asserted at byte 2 bit 3, then start -> cs=1 and wclk=0 one cycle after greset, no done; new frame begins with byte 0 and is complete.
REQ-025 start pulses during busy and in the done cycle -> ignored; exactly one frame sent, busy falls with done.
REQ-026 Receiver model (cs low => capture din on wclk rise into 8192-bit memory, address counter cleared on cs high) -> memory matches the 1024-byte buffer bit for bit.
